// File: rtl/vexec_pkg.sv
// rtl/vexec_pkg.sv - opcodes, FSM state encoding, flag positions and width helpers for vexec_seq
package vexec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Flag value at accept: Z starts set and is cleared by any non-zero write
  localparam logic [3:0] FLAGS_INIT = 4'b0100;

  // Length field must hold 0..MAXVL inclusive
  function automatic int vlw_of(input int maxvl);
    return $clog2(maxvl + 1);
  endfunction

  function automatic int iw_of(input int maxvl);
    return (maxvl > 1) ? $clog2(maxvl) : 1;
  endfunction

  function automatic int rw_of(input int nvreg);
    return (nvreg > 1) ? $clog2(nvreg) : 1;
  endfunction

endpackage

// File: rtl/vexec_lane.sv
// rtl/vexec_lane.sv - single-element combinational ALU with N/Z/C/V outputs
module vexec_lane
  import vexec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] add_r;
  logic [WIDTH:0] sub_r;

  // Subtract as a + ~b + 1 so the carry-out is directly NOT borrow
  assign add_r = {1'b0, a} + {1'b0, b};
  assign sub_r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // Result and carry/overflow selection; invalid opcodes yield zero
  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        y = add_r[WIDTH-1:0];
        c = add_r[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y = sub_r[WIDTH-1:0];
        c = sub_r[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y = a & b;
      OP_ORR:  y = a | b;
      OP_EOR:  y = a ^ b;
      OP_MOV:  y = b;
      default: y = '0;
    endcase
    n = y[WIDTH-1];
    z = (y == '0);
  end

endmodule

// File: rtl/vexec_seq.sv
// rtl/vexec_seq.sv - multi-cycle vector sequencer; optional reduction sum under VEXEC_REDUCE_EN
module vexec_seq
  import vexec_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int LANES = 2,
  parameter  int MAXVL = 8,
  parameter  int NVREG = 16,
  localparam int VLW   = vlw_of(MAXVL),
  localparam int IW    = iw_of(MAXVL),
  localparam int RW    = rw_of(NVREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [VLW-1:0]   vl,
  input  logic [RW-1:0]    vd,
  input  logic [RW-1:0]    va,
  input  logic [RW-1:0]    vb,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags,
  input  logic             ld_we,
  input  logic [RW-1:0]    ld_reg,
  input  logic [IW-1:0]    ld_idx,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [RW-1:0]    dbg_reg,
  input  logic [IW-1:0]    dbg_idx,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] red_sum
);

  state_t state;
  state_t state_nx;

  logic             accept;
  logic             last_beat;
  logic [VLW-1:0]   eff_vl;
  logic [VLW-1:0]   idx;
  logic [VLW-1:0]   vl_q;
  logic [2:0]       op_q;
  logic [RW-1:0]    vd_q;
  logic [RW-1:0]    va_q;
  logic [RW-1:0]    vb_q;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0] vreg [NVREG][MAXVL];

  logic [LANES-1:0] lane_act;
  logic [IW-1:0]    lane_idx [LANES];
  logic [WIDTH-1:0] lane_a   [LANES];
  logic [WIDTH-1:0] lane_b   [LANES];
  logic [WIDTH-1:0] lane_y   [LANES];
  logic [LANES-1:0] lane_n;
  logic [LANES-1:0] lane_z;
  logic [LANES-1:0] lane_c;
  logic [LANES-1:0] lane_v;

  logic beat_n;
  logic beat_z;
  logic beat_c;
  logic beat_v;

  assign eff_vl    = (vl > VLW'(MAXVL)) ? VLW'(MAXVL) : vl;
  assign last_beat = (int'(idx) + LANES) >= int'(vl_q);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign flags     = flags_q;
  assign dbg_data  = vreg[dbg_reg][dbg_idx];

  // Per-lane element select and ALU; inactive lanes read element 0 and write nothing
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_act[k] = (int'(idx) + k) < int'(vl_q);
    assign lane_idx[k] = lane_act[k] ? IW'(int'(idx) + k) : '0;
    assign lane_a[k]   = vreg[va_q][lane_idx[k]];
    assign lane_b[k]   = vreg[vb_q][lane_idx[k]];

    vexec_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a  (lane_a[k]),
      .b  (lane_b[k]),
      .op (op_q),
      .y  (lane_y[k]),
      .n  (lane_n[k]),
      .z  (lane_z[k]),
      .c  (lane_c[k]),
      .v  (lane_v[k])
    );
  end

  // Beat flags: N/C/V from the highest active lane, Z only if every active result is zero
  always_comb begin
    beat_n = 1'b0;
    beat_z = 1'b1;
    beat_c = 1'b0;
    beat_v = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_act[k]) begin
        beat_n = lane_n[k];
        beat_c = lane_c[k];
        beat_v = lane_v[k];
        beat_z = beat_z & lane_z[k];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; a zero-length op skips straight to the done cycle
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (eff_vl == '0) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (last_beat) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operation latch, beat counter and flag accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      vl_q    <= '0;
      op_q    <= '0;
      vd_q    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      flags_q <= '0;
    end else if (accept) begin
      idx     <= '0;
      vl_q    <= eff_vl;
      op_q    <= op;
      vd_q    <= vd;
      va_q    <= va;
      vb_q    <= vb;
      flags_q <= FLAGS_INIT;
    end else if (state == ST_EXEC) begin
      idx             <= last_beat ? '0 : idx + VLW'(LANES);
      flags_q[FLAG_N] <= beat_n;
      flags_q[FLAG_C] <= beat_c;
      flags_q[FLAG_V] <= beat_v;
      flags_q[FLAG_Z] <= flags_q[FLAG_Z] & beat_z;
    end
  end

  // Register file writes: loads only while idle, lane results only during EXEC; reset blocks the in-flight beat
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_IDLE && ld_we) begin
        vreg[ld_reg][ld_idx] <= ld_data;
      end else if (state == ST_EXEC) begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_act[k]) vreg[vd_q][lane_idx[k]] <= lane_y[k];
        end
      end
    end
  end

`ifdef VEXEC_REDUCE_EN
  logic [WIDTH-1:0] beat_sum;
  logic [WIDTH-1:0] red_q;

  // Sum of this beat's active lane results
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_act[k]) beat_sum = beat_sum + lane_y[k];
    end
  end

  // Running reduction, cleared at accept and frozen outside EXEC
  always_ff @(posedge clk) begin
    if (reset)                  red_q <= '0;
    else if (accept)            red_q <= '0;
    else if (state == ST_EXEC)  red_q <= red_q + beat_sum;
  end

  assign red_sum = red_q;
`else
  assign red_sum = '0;
`endif

endmodule

// File: tb/tb_vexec_seq.sv
// tb/tb_vexec_seq.sv - directed self-checking bench for vexec_seq (LANES=2, MAXVL=8)
module tb_vexec_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [3:0]  vl;
  logic [3:0]  vd;
  logic [3:0]  va;
  logic [3:0]  vb;
  logic        busy;
  logic        done;
  logic [3:0]  flags;
  logic        ld_we;
  logic [3:0]  ld_reg;
  logic [2:0]  ld_idx;
  logic [31:0] ld_data;
  logic [3:0]  dbg_reg;
  logic [2:0]  dbg_idx;
  logic [31:0] dbg_data;
  logic [31:0] red_sum;

  int n_cmp = 0;
  int n_err = 0;

  vexec_seq #(
    .WIDTH(32),
    .LANES(2),
    .MAXVL(8),
    .NVREG(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .vl       (vl),
    .vd       (vd),
    .va       (va),
    .vb       (vb),
    .busy     (busy),
    .done     (done),
    .flags    (flags),
    .ld_we    (ld_we),
    .ld_reg   (ld_reg),
    .ld_idx   (ld_idx),
    .ld_data  (ld_data),
    .dbg_reg  (dbg_reg),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data),
    .red_sum  (red_sum)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_elem(input logic [3:0] r, input logic [2:0] i, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_reg  = r;
    ld_idx  = i;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic read_elem(input logic [3:0] r, input logic [2:0] i, output logic [31:0] d);
    dbg_reg = r;
    dbg_idx = i;
    #1;
    d = dbg_data;
  endtask

  // Issue one op; cyc counts cycles from accept, the first post-accept cycle being 1
  task automatic run_op(input logic [2:0] o, input logic [3:0] d, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] l, input bit hold,
                        output int cyc, output logic [3:0] fl);
    start = 1'b1;
    op = o; vd = d; va = a; vb = b; vl = l;
    tick();
    if (!hold) start = 1'b0;
    if (hold) begin
      ld_we = 1'b1; ld_reg = 4'd9; ld_idx = 3'd0; ld_data = 32'hDEAD;
    end
    op = 3'b111; vd = 4'd15; va = 4'd15; vb = 4'd15; vl = 4'd3;
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    fl = flags;
    start = 1'b0;
    ld_we = 1'b0;
    tick();
    check_eq("done_is_pulse", {31'd0, done}, 32'd0);
    check_eq("busy_drops", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          cyc;
    logic [3:0]  fl;
    logic [31:0] d;
    logic [31:0] exp_red;

    reset = 1'b1; start = 1'b0; op = '0; vl = '0; vd = '0; va = '0; vb = '0;
    ld_we = 1'b0; ld_reg = '0; ld_idx = '0; ld_data = '0; dbg_reg = '0; dbg_idx = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_flags", {28'd0, flags}, 32'd0);
    check_eq("rst_red_sum", red_sum, 32'd0);

    for (int i = 0; i < 8; i++) begin
      load_elem(4'd1, 3'(i), 32'(i + 1));
      load_elem(4'd2, 3'(i), 32'(10 * (i + 1)));
      load_elem(4'd11, 3'(i), 32'hAAAA);
    end
    load_elem(4'd4, 3'd0, 32'h7FFF_FFFF);
    load_elem(4'd5, 3'd0, 32'h0000_0001);
    load_elem(4'd7, 3'd0, 32'h55);
    load_elem(4'd9, 3'd0, 32'h1234);
    read_elem(4'd1, 3'd7, d);
    check_eq("load_visible", d, 32'd8);

    // Test 1: ADD v3 = v1 + v2, vl=8
    run_op(3'b000, 4'd3, 4'd1, 4'd2, 4'd8, 1'b0, cyc, fl);
    check_eq("t1_latency", 32'(cyc), 32'd5);
    check_eq("t1_flags", {28'd0, fl}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      read_elem(4'd3, 3'(i), d);
      check_eq($sformatf("t1_v3_%0d", i), d, 32'(11 * (i + 1)));
    end
`ifdef VEXEC_REDUCE_EN
    exp_red = 32'd396;
`else
    exp_red = 32'd0;
`endif
    check_eq("t1_red_sum", red_sum, exp_red);
    tick();

    // Test 2: SUB v3 = v1 - v1, vl=5
    run_op(3'b001, 4'd3, 4'd1, 4'd1, 4'd5, 1'b0, cyc, fl);
    check_eq("t2_latency", 32'(cyc), 32'd4);
    check_eq("t2_flags", {28'd0, fl}, 32'h6);
    for (int i = 0; i < 8; i++) begin
      read_elem(4'd3, 3'(i), d);
      check_eq($sformatf("t2_v3_%0d", i), d, (i < 5) ? 32'd0 : 32'(11 * (i + 1)));
    end
    tick();

    // Test 3: signed overflow on the last element
    run_op(3'b000, 4'd6, 4'd4, 4'd5, 4'd1, 1'b0, cyc, fl);
    check_eq("t3_latency", 32'(cyc), 32'd2);
    check_eq("t3_flags", {28'd0, fl}, 32'h9);
    read_elem(4'd6, 3'd0, d);
    check_eq("t3_result", d, 32'h8000_0000);
    tick();

    // Test 4a: vl=0 completes next cycle, no writes, Z=1
    run_op(3'b000, 4'd7, 4'd1, 4'd2, 4'd0, 1'b0, cyc, fl);
    check_eq("t4_vl0_latency", 32'(cyc), 32'd1);
    check_eq("t4_vl0_flags", {28'd0, fl}, 32'h4);
    read_elem(4'd7, 3'd0, d);
    check_eq("t4_vl0_nowrite", d, 32'h55);
    check_eq("t4_vl0_red_sum", red_sum, 32'd0);
    tick();

    // Test 4b: vl=12 clamps to 8
    run_op(3'b000, 4'd8, 4'd1, 4'd2, 4'd12, 1'b0, cyc, fl);
    check_eq("t4_vl12_latency", 32'(cyc), 32'd5);
    check_eq("t4_vl12_flags", {28'd0, fl}, 32'h0);
    read_elem(4'd8, 3'd0, d);
    check_eq("t4_vl12_e0", d, 32'd11);
    read_elem(4'd8, 3'd7, d);
    check_eq("t4_vl12_e7", d, 32'd88);
    check_eq("t4_vl12_red_sum", red_sum, exp_red);
    tick();

    // Test 5: fully aliased ADD with start and ld_we held high while busy
    run_op(3'b000, 4'd1, 4'd1, 4'd1, 4'd8, 1'b1, cyc, fl);
    check_eq("t5_latency", 32'(cyc), 32'd5);
    for (int i = 0; i < 8; i++) begin
      read_elem(4'd1, 3'(i), d);
      check_eq($sformatf("t5_v1_%0d", i), d, 32'(2 * (i + 1)));
    end
    read_elem(4'd9, 3'd0, d);
    check_eq("t5_ld_dropped", d, 32'h1234);
    tick();
    check_eq("t5_no_restart", {31'd0, busy}, 32'd0);

    // ORR then an invalid opcode that still writes zeros
    run_op(3'b011, 4'd10, 4'd2, 4'd2, 4'd3, 1'b0, cyc, fl);
    check_eq("orr_flags", {28'd0, fl}, 32'h0);
    read_elem(4'd10, 3'd2, d);
    check_eq("orr_e2", d, 32'd30);
    tick();
    run_op(3'b110, 4'd10, 4'd2, 4'd2, 4'd2, 1'b0, cyc, fl);
    check_eq("inv_flags", {28'd0, fl}, 32'h4);
    read_elem(4'd10, 3'd1, d);
    check_eq("inv_e1", d, 32'd0);
    read_elem(4'd10, 3'd2, d);
    check_eq("inv_e2_kept", d, 32'd30);
    tick();

    // Test 6: reset during the second EXEC beat
    start = 1'b1; op = 3'b000; vd = 4'd11; va = 4'd2; vb = 4'd2; vl = 4'd8;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_done", {31'd0, done}, 32'd0);
    tick();
    check_eq("t6_no_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      read_elem(4'd11, 3'(i), d);
      check_eq($sformatf("t6_v11_%0d", i), d, (i < 2) ? 32'(20 * (i + 1)) : 32'hAAAA);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
